// File: rtl/bus_pkg.sv
// Shared definitions for the microcontroller data bus: mode encodings,
// bus widths and the arbiter state type. The bus masters and slaves
// import this package as well as the arbiter.
package bus_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_ADDR_W = 32;

    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_t;

    // Only reads and writes move data. Idle and the reserved code do not.
    function automatic logic is_beat_mode(input logic [1:0] mode);
        return (mode == BUS_READ) || (mode == BUS_WRITE);
    endfunction

endpackage

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus. Master 0 is the
// datapath core and master 1 is a secondary master such as DMA or debug.
// Ownership is bounded by MAX_BURST beats whenever the other master is
// waiting. The owner's beat is forwarded combinationally to the slaves,
// and read data is registered back to the master that issued the read.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic [1:0]            m0_mode,
    input  logic [BUS_ADDR_W-1:0] m0_addr,
    input  logic [BUS_DATA_W-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic [BUS_DATA_W-1:0] m0_rdata,
    output logic                  m0_rvalid,
    input  logic                  m1_req,
    input  logic [1:0]            m1_mode,
    input  logic [BUS_ADDR_W-1:0] m1_addr,
    input  logic [BUS_DATA_W-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic [BUS_DATA_W-1:0] m1_rdata,
    output logic                  m1_rvalid,
    output logic [1:0]            data_bus_mode,
    output logic [BUS_ADDR_W-1:0] data_bus_addr,
    output logic [BUS_DATA_W-1:0] data_bus_wdata,
    input  logic [BUS_DATA_W-1:0] data_bus_rdata
);

    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  last_owner;
    logic                  last_owner_next;
    logic [7:0]            burst_cnt;
    logic [7:0]            burst_cnt_next;

    logic                  own_req;
    logic                  other_req;
    logic [1:0]            own_mode;
    logic [BUS_ADDR_W-1:0] own_addr;
    logic [BUS_DATA_W-1:0] own_wdata;
    logic                  beat;
    logic                  burst_done;

    logic [BUS_ADDR_W-1:0] addr_hold;
    logic [BUS_DATA_W-1:0] wdata_hold;

    // Select the current owner's request and bus fields, the other master's request is kept for handover decisions
    always_comb begin
        own_req   = 1'b0;
        other_req = 1'b0;
        own_mode  = BUS_IDLE;
        own_addr  = m0_addr;
        own_wdata = m0_wdata;
        case (state)
            OWN0: begin
                own_req   = m0_req;
                other_req = m1_req;
                own_mode  = m0_mode;
                own_addr  = m0_addr;
                own_wdata = m0_wdata;
            end
            OWN1: begin
                own_req   = m1_req;
                other_req = m0_req;
                own_mode  = m1_mode;
                own_addr  = m1_addr;
                own_wdata = m1_wdata;
            end
            default: begin
                own_req   = 1'b0;
                other_req = 1'b0;
            end
        endcase
    end

    // A saturated counter still counts as the last allowed beat once the other master starts waiting
    assign beat       = own_req && is_beat_mode(own_mode);
    assign burst_done = beat && (burst_cnt >= BURST_LAST);

    // Next owner: round-robin tie-break from idle, release on dropped request, forced handover at the burst limit
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_next = last_owner ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_next = OWN0;
                end else if (m1_req) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!m0_req) begin
                    state_next = m1_req ? OWN1 : IDLE;
                end else if (burst_done && other_req) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                if (!m1_req) begin
                    state_next = m0_req ? OWN0 : IDLE;
                end else if (burst_done && other_req) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Burst counter restarts on every ownership change and saturates while nobody else is waiting; the pointer remembers who entered ownership last
    always_comb begin
        burst_cnt_next  = burst_cnt;
        last_owner_next = last_owner;
        if (state_next != state) begin
            burst_cnt_next = 8'd0;
            if (state_next == OWN0) begin
                last_owner_next = 1'b0;
            end else if (state_next == OWN1) begin
                last_owner_next = 1'b1;
            end
        end else if (beat && (burst_cnt != BURST_MAX)) begin
            burst_cnt_next = burst_cnt + 8'd1;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= 8'd0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            burst_cnt  <= burst_cnt_next;
        end
    end

    // Remember the last forwarded address and write data so the bus stays quiet between beats
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else if (beat) begin
            addr_hold  <= own_addr;
            wdata_hold <= own_wdata;
        end
    end

    // Capture read data for the master that issued the read, even when ownership moves at the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (beat && (own_mode == BUS_READ)) begin
                if (state == OWN0) begin
                    m0_rdata  <= data_bus_rdata;
                    m0_rvalid <= 1'b1;
                end else begin
                    m1_rdata  <= data_bus_rdata;
                    m1_rvalid <= 1'b1;
                end
            end
        end
    end

    assign m0_gnt         = (state == OWN0);
    assign m1_gnt         = (state == OWN1);
    assign data_bus_mode  = beat ? own_mode : BUS_IDLE;
    assign data_bus_addr  = beat ? own_addr : addr_hold;
    assign data_bus_wdata = beat ? own_wdata : wdata_hold;

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter for the shared microcontroller data bus, placed between the bus masters (m0 = `datapath` core, m1 = secondary master such as DMA or debug) and the bus slaves (`data_memory`, `leds`). It grants ownership round-robin with a bounded burst length, muxes the owner's address, write data and mode onto the bus, and returns registered read data to the master that issued the read.

## Interface
Parameters:
- MAX_BURST, 4: maximum consecutive accepted beats per ownership while the other master is requesting; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 requests the bus.
- m0_mode  in  2  master 0 bus mode: 00 idle, 01 read, 10 write, 11 reserved.
- m0_addr  in  32  master 0 address.
- m0_wdata  in  32  master 0 write data.
- m0_gnt  out  1  master 0 owns the bus this cycle.
- m0_rdata  out  32  read data returned to master 0.
- m0_rvalid  out  1  m0_rdata valid, one-cycle pulse.
- m1_req, m1_mode, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: identical to the m0 ports, for master 1.
- data_bus_mode  out  2  mode driven to the slaves.
- data_bus_addr  out  32  address driven to the slaves.
- data_bus_wdata  out  32  write data driven to the slaves.
- data_bus_rdata  in  32  read data returned by the selected slave.

## Operation
- FSM states: IDLE, OWN0, OWN1. Registered state.
- The grant signal is the state decode: mX_gnt=1 exactly when the state is OWNX.
- Round-robin pointer `last_owner` holds the most recent owner. Its reset value is 1, so m0 wins the first tie.
- IDLE state:
  - If only one master requests, that master is next owner.
  - If both request, the master that is not `last_owner` is next owner.
  - If neither requests, stay in IDLE.
- Beat: a cycle in OWNX with mX_req=1 and mX_mode being 01 or 10. A beat is accepted in the cycle it is presented and increments the 8-bit burst counter.
- OWNX transitions:
  - mX_req=0: go to OWNY if mY_req=1, otherwise IDLE.
  - Beat that brings the counter to MAX_BURST while mY_req=1: forced handover to OWNY.
  - Otherwise: stay in OWNX. The counter saturates at MAX_BURST while the other master is idle.
- The counter clears on every state change. `last_owner` updates on entry to OWNX.
- Bus mux:
  - In OWNX with a beat, the data_bus_* outputs carry master X's mode, address and write data.
  - Otherwise data_bus_mode=00, and address and write data hold their last values.
- Mode 11 is never forwarded. It is treated as a non-beat: bus mode 00, no count, ownership kept while req is held.
- Read return:
  - On a read beat, data_bus_rdata is captured at the clock edge into the issuing master's rdata register, with that master's rvalid pulsed for one cycle.
  - This holds even if ownership changes at the same edge.
  - rdata holds until that master's next read.

## Timing
- Grant latency: a request seen in IDLE at cycle n gives gnt=1 and first beat accepted in cycle n+1.
- Back-to-back beats: one per cycle while owned.
- Handover: the old owner's last beat is in cycle n, the new owner's gnt and first beat are in cycle n+1. There is no turnaround cycle.
- Read data: beat in cycle n, so rdata/rvalid appear in cycle n+1.
- Reset values, asserted asynchronously and held while reset=0:
  - state IDLE, last_owner 1, counter 0.
  - m0_gnt, m1_gnt, m0_rvalid, m1_rvalid all 0; m0_rdata, m1_rdata 0.
  - data_bus_mode 00, data_bus_addr 0, data_bus_wdata 0.
- Reset mid-burst: ownership is dropped immediately and a pending rvalid is suppressed.
- Slaves respond combinationally within the beat cycle. There are no wait states.

## Structure
- Shared package `bus_pkg`:
  - Mode constants BUS_IDLE=2'b00, BUS_READ=2'b01, BUS_WRITE=2'b10, BUS_RSVD=2'b11.
  - Typedef `arb_state_t` {IDLE, OWN0, OWN1}.
  - Data and address width constants (32). `data_memory`, `leds` and `datapath` reuse these.
- Single module, no sub-module. FSM, counter, mux and read-return registers are inline.

## Test plan
- Reset, then m0 alone: m0_req=1, read at 0x100 with slave data 0xDEADBEEF. Expect m0_gnt=1 one cycle after the request, data_bus_mode=01 with addr 0x100, and m0_rdata=0xDEADBEEF with m0_rvalid pulsing one cycle later.
- Simultaneous first request from both masters: expect m0 granted first, m1 granted after m0 drops req, with no idle cycle between.
- Both masters streaming writes with MAX_BURST=4: expect ownership alternating every 4 beats, data_bus_wdata sequence matching 4 m0 words then 4 m1 words, and no beat lost or duplicated.
- m1 alone issues 10 writes: no forced handover, counter saturates, m1_gnt stays high for all 10 cycles.
- m0 read on its last allowed beat while handing over to m1: m0_rvalid fires during m1's first beat, m1_rvalid stays 0.
- Mode 11 from the owner: data_bus_mode=00, no count, gnt retained. Assert reset mid-burst: all outputs reach reset values immediately and the in-flight rvalid is not emitted.
